// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// The single-entry response register allows one result per cycle when it is drained back-to-back.
module alu_arbiter #(
  parameter int unsigned DW        = 32,
  parameter logic [3:0]  NDEF_TYPE = 4'd8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [3:0]    req0_type,
  input  logic [DW-1:0] req0_src1,
  input  logic [DW-1:0] req0_src2,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [3:0]    req1_type,
  input  logic [DW-1:0] req1_src1,
  input  logic [DW-1:0] req1_src2,
  output logic          req1_ready,
  output logic [3:0]    alu_type,
  output logic [DW-1:0] alu_src1,
  output logic [DW-1:0] alu_src2,
  input  logic [DW-1:0] alu_result,
  output logic          rsp_valid,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_result,
  output logic          rsp_err,
  input  logic          rsp_ready
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          ptr_r;
  logic          can_issue_s;
  logic          grant_s;
  logic          winner_s;
  logic [3:0]    win_type_s;
  logic [DW-1:0] win_src1_s;
  logic [DW-1:0] win_src2_s;
  logic          undef_s;
  logic          rsp_valid_r;
  logic          rsp_id_r;
  logic [DW-1:0] rsp_result_r;
  logic          rsp_err_r;

  // Issue permission and round-robin winner selection
  always_comb begin
    can_issue_s = 1'b0;
    grant_s     = 1'b0;
    winner_s    = ptr_r;
    if (rst) begin
      can_issue_s = 1'b0;
    end else if (state_r == IDLE) begin
      can_issue_s = 1'b1;
    end else if (rsp_ready) begin
      can_issue_s = 1'b1;
    end else begin
      can_issue_s = 1'b0;
    end
    if (can_issue_s && (req0_valid || req1_valid)) begin
      grant_s = 1'b1;
      if (req0_valid && req1_valid) begin
        winner_s = ptr_r;
      end else if (req0_valid) begin
        winner_s = 1'b0;
      end else begin
        winner_s = 1'b1;
      end
    end else begin
      grant_s  = 1'b0;
      winner_s = ptr_r;
    end
  end

  // Winner payload mux
  always_comb begin
    win_type_s = req0_type;
    win_src1_s = req0_src1;
    win_src2_s = req0_src2;
    if (winner_s) begin
      win_type_s = req1_type;
      win_src1_s = req1_src1;
      win_src2_s = req1_src2;
    end else begin
      win_type_s = req0_type;
      win_src1_s = req0_src1;
      win_src2_s = req0_src2;
    end
    undef_s = (win_type_s >= NDEF_TYPE);
  end

  // Shared-ALU drive and ready strobes; the ALU sees a neutral op when nothing is granted
  always_comb begin
    alu_type   = NDEF_TYPE;
    alu_src1   = {DW{1'b0}};
    alu_src2   = {DW{1'b0}};
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (grant_s) begin
      alu_type   = win_type_s;
      alu_src1   = win_src1_s;
      alu_src2   = win_src2_s;
      req0_ready = ~winner_s;
      req1_ready = winner_s;
    end else begin
      alu_type   = NDEF_TYPE;
      alu_src1   = {DW{1'b0}};
      alu_src2   = {DW{1'b0}};
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          state_nxt_s = FULL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FULL: begin
        if (!rsp_ready) begin
          state_nxt_s = FULL;
        end else if (grant_s) begin
          state_nxt_s = FULL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, priority pointer and response register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      ptr_r        <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 1'b0;
      rsp_result_r <= {DW{1'b0}};
      rsp_err_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (grant_s) begin
        ptr_r        <= ~winner_s;
        rsp_valid_r  <= 1'b1;
        rsp_id_r     <= winner_s;
        rsp_err_r    <= undef_s;
        // An undefined op returns zero whatever the ALU produced for it
        rsp_result_r <= undef_s ? {DW{1'b0}} : alu_result;
      end else if ((state_r == FULL) && rsp_ready) begin
        rsp_valid_r <= 1'b0;
      end else begin
        rsp_valid_r <= rsp_valid_r;
      end
    end
  end

  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_result = rsp_result_r;
  assign rsp_err    = rsp_err_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by random traffic,
// all compared against a cycle-level reference model of the arbiter and response slot.
module tb_alu_arbiter;
  localparam int unsigned DW   = 32;
  localparam logic [3:0]  NDEF = 4'd8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          rsp_ready;
  logic          r_v [2];
  logic [3:0]    r_t [2];
  logic [DW-1:0] r_a [2];
  logic [DW-1:0] r_b [2];

  logic          req0_ready, req1_ready;
  logic [3:0]    alu_type;
  logic [DW-1:0] alu_src1, alu_src2, alu_result;
  logic          rsp_valid, rsp_id, rsp_err;
  logic [DW-1:0] rsp_result;

  alu_arbiter #(.DW(DW), .NDEF_TYPE(NDEF)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(r_v[0]), .req0_type(r_t[0]), .req0_src1(r_a[0]), .req0_src2(r_b[0]),
    .req0_ready(req0_ready),
    .req1_valid(r_v[1]), .req1_type(r_t[1]), .req1_src1(r_a[1]), .req1_src2(r_b[1]),
    .req1_ready(req1_ready),
    .alu_type(alu_type), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready)
  );

  function automatic logic [DW-1:0] alu_ref(input logic [3:0] t, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (t)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a << (b % DW);
      4'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4: return a ^ b;
      4'd5: return a >> (b % DW);
      4'd6: return a | b;
      4'd7: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  // Shared ALU; garbage on undefined ops so the arbiter must zero it itself
  always_comb alu_result = (alu_type < NDEF) ? alu_ref(alu_type, alu_src1, alu_src2) : 32'hDEAD_BEEF;

  bit            m_full, m_ptr, m_vld, m_id, m_err;
  logic [DW-1:0] m_res;
  bit            last_g, last_w;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int n, input bit v, input logic [3:0] t,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
    r_v[n] = v; r_t[n] = t; r_a[n] = a; r_b[n] = b;
  endtask

  task automatic step();
    bit            g, w;
    bit            e;
    logic [DW-1:0] res;
    #2;
    g = 1'b0; w = 1'b0;
    if (!rst && (!m_full || rsp_ready) && (r_v[0] || r_v[1])) begin
      g = 1'b1;
      w = (r_v[0] && r_v[1]) ? m_ptr : !r_v[0];
    end
    chk("req0_ready", req0_ready, g && !w);
    chk("req1_ready", req1_ready, g && w);
    chk("alu_type", alu_type, g ? r_t[w] : NDEF);
    chk("alu_src1", alu_src1, g ? r_a[w] : 32'd0);
    chk("alu_src2", alu_src2, g ? r_b[w] : 32'd0);
    e   = (r_t[w] >= NDEF);
    res = e ? 32'd0 : alu_ref(r_t[w], r_a[w], r_b[w]);
    @(posedge clk);
    if (rst) begin
      m_full = 1'b0; m_ptr = 1'b0; m_vld = 1'b0; m_id = 1'b0; m_err = 1'b0; m_res = 32'd0;
    end else if (g) begin
      m_full = 1'b1; m_vld = 1'b1; m_id = w; m_err = e; m_res = res; m_ptr = !w;
    end else if (m_full && rsp_ready) begin
      m_full = 1'b0; m_vld = 1'b0;
    end
    last_g = g; last_w = w;
    #1;
    chk("rsp_valid", rsp_valid, m_vld);
    chk("rsp_id", rsp_id, m_id);
    chk("rsp_result", rsp_result, m_res);
    chk("rsp_err", rsp_err, m_err);
  endtask

  // New payload only for an idle requester or one just granted; a waiting request stays stable
  task automatic refill();
    for (int n = 0; n < 2; n++) begin
      if (!r_v[n] || (last_g && (int'(last_w) == n))) begin
        r_v[n] = ($urandom % 4) != 0;
        r_t[n] = 4'($urandom_range(0, 10));
        r_a[n] = $urandom;
        r_b[n] = ($urandom % 2) ? ($urandom % 40) : $urandom;
      end
    end
  endtask

  initial begin
    m_full = 1'b0; m_ptr = 1'b0; m_vld = 1'b0; m_id = 1'b0; m_err = 1'b0; m_res = 32'd0;
    last_g = 1'b0; last_w = 1'b0;
    rst = 1'b1; rsp_ready = 1'b0;
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    step(); step();
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_result", rsp_result, 32'd0);

    // Single ADD from requester 0
    rst = 1'b0; rsp_ready = 1'b1;
    set_req(0, 1'b1, 4'd0, 32'd5, 32'd3);
    step();
    chk("add_valid", rsp_valid, 1'b1);
    chk("add_id", rsp_id, 1'b0);
    chk("add_result", rsp_result, 32'd8);
    chk("add_err", rsp_err, 1'b0);
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    step();
    chk("drain_valid", rsp_valid, 1'b0);
    chk("drain_hold_result", rsp_result, 32'd8);

    // Both requesters always valid: strict alternation starting at 0
    rst = 1'b1; step(); rst = 1'b0;
    set_req(0, 1'b1, 4'd1, 32'd10, 32'd4);
    set_req(1, 1'b1, 4'd4, 32'hF0, 32'h0F);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("alt_id", rsp_id, (i % 2 == 1) ? 1'b1 : 1'b0);
      chk("alt_result", rsp_result, (i % 2 == 1) ? 32'hFF : 32'd6);
    end

    // Back-pressure for three cycles, then release
    rsp_ready = 1'b0;
    repeat (3) step();
    chk("hold_id", rsp_id, 1'b1);
    chk("hold_result", rsp_result, 32'hFF);
    rsp_ready = 1'b1;
    step();
    chk("release_id", rsp_id, 1'b0);
    chk("release_result", rsp_result, 32'd6);

    // Undefined type from requester 1
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(1, 1'b1, 4'd9, 32'd1, 32'd1);
    step();
    chk("ndef_id", rsp_id, 1'b1);
    chk("ndef_err", rsp_err, 1'b1);
    chk("ndef_result", rsp_result, 32'd0);

    // Reset while holding a response with requests pending
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 4'd6, 32'h0A, 32'h50);
    set_req(1, 1'b1, 4'd7, 32'hFF, 32'h0F);
    step();
    rst = 1'b1;
    step();
    chk("rst_full_valid", rsp_valid, 1'b0);
    rst = 1'b0; rsp_ready = 1'b1;
    step();
    chk("rst_first_id", rsp_id, 1'b0);
    chk("rst_first_result", rsp_result, 32'h5A);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      refill();
      rsp_ready = ($urandom % 3) != 0;
      rst       = ($urandom % 60) == 0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
